// File: rtl/reg_ovr_pkg.sv
// Shared state/op encodings and default parameters for the register override scheduler.
package reg_ovr_pkg;

    localparam int unsigned NREQ_DEF     = 4;
    localparam int unsigned WIDTH_DEF    = 8;
    localparam int unsigned MAX_HOLD_DEF = 16;
    localparam int unsigned NREQ_MIN     = 2;
    localparam int unsigned NREQ_MAX     = 8;

    localparam logic OP_SET = 1'b1;
    localparam logic OP_CLR = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_APPLY   = 2'd1,
        ST_HOLD    = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

endpackage

// File: rtl/reg_ovr_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the first active request at or after ptr wins (one-hot).
module rr_arbiter
    import reg_ovr_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    output logic [NREQ-1:0]         gnt_c
);

    localparam int unsigned PTR_W = $clog2(NREQ);

    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        gnt_c = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = PTR_W'((32'(ptr_i) + i) % NREQ);
            if (!found && req_i[idx]) begin
                gnt_c[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_ovr_sched.sv
// Register-override scheduler: round-robin grants a set/clear override of a flop bank.
// Optional feature: define OVR_TIMEOUT_EN to bound HOLD to MAX_HOLD cycles and add the timeout port.
module reg_ovr_sched
    import reg_ovr_pkg::*;
#(
    parameter int unsigned NREQ     = NREQ_DEF,
    parameter int unsigned WIDTH    = WIDTH_DEF,
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       req_val,
    input  logic [NREQ*WIDTH-1:0] req_mask,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      ovr_set,
    output logic [WIDTH-1:0]      ovr_clr,
    output logic                  busy,
    output logic                  done
`ifdef OVR_TIMEOUT_EN
    ,
    output logic                  timeout
`endif
);

    localparam int unsigned PTR_W = $clog2(NREQ);

    if (NREQ < NREQ_MIN || NREQ > NREQ_MAX || WIDTH < 1 || MAX_HOLD < 1) begin : g_param_chk
        $error("reg_ovr_sched: parameter out of range");
    end

    state_e           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d, ptr_nxt;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [WIDTH-1:0] set_q, set_d, clr_q, clr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [NREQ-1:0]  arb_gnt;
    logic [WIDTH-1:0] mask_sel;
    logic             val_sel;
    logic             release_c;

`ifdef OVR_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`endif

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_c (arb_gnt)
    );

    // Winner's payload and the pointer value that follows it
    always_comb begin
        mask_sel = '0;
        val_sel  = OP_CLR;
        ptr_nxt  = ptr_q;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
                mask_sel = req_mask[i*WIDTH +: WIDTH];
                val_sel  = req_val[i];
                ptr_nxt  = PTR_W'((i + 1) % NREQ);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        set_d     = set_q;
        clr_d     = clr_q;
        done_d    = 1'b0;
        release_c = 1'b0;
`ifdef OVR_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_APPLY;
                    ptr_d   = ptr_nxt;
                    gnt_d   = arb_gnt;
                    set_d   = mask_sel & {WIDTH{val_sel == OP_SET}};
                    clr_d   = mask_sel & {WIDTH{val_sel == OP_CLR}};
                end
            end
            ST_APPLY: begin
                state_d = ST_HOLD;
`ifdef OVR_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_HOLD: begin
                if (!(|(req & gnt_q))) begin
                    release_c = 1'b1;
                end
`ifdef OVR_TIMEOUT_EN
                else if (cnt_q == CNT_W'(MAX_HOLD - 1)) begin
                    release_c = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Outputs drop on the edge into RELEASE, together with the done pulse
        if (release_c) begin
            state_d = ST_RELEASE;
            gnt_d   = '0;
            set_d   = '0;
            clr_d   = '0;
            done_d  = 1'b1;
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            set_q     <= '0;
            clr_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef OVR_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            set_q     <= set_d;
            clr_q     <= clr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef OVR_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign ovr_set = set_q;
    assign ovr_clr = clr_q;
    assign busy    = busy_q;
    assign done    = done_q;
`ifdef OVR_TIMEOUT_EN
    assign timeout = timeout_q;
`endif

endmodule

// File: tb/tb_reg_ovr_sched.sv
// Self-checking bench for reg_ovr_sched: per-cycle vector table plus hand-built hold/timeout sequences.
module tb_reg_ovr_sched;

    localparam int unsigned NREQ     = 4;
    localparam int unsigned WIDTH    = 8;
    localparam int unsigned MAX_HOLD = 16;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  val;
        logic [31:0] mask;
        logic [3:0]  gnt;
        logic [7:0]  set;
        logic [7:0]  clr;
        logic        busy;
        logic        done;
        logic        to;
        string       name;
    } vec_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       req_val;
    logic [NREQ*WIDTH-1:0] req_mask;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      ovr_set;
    logic [WIDTH-1:0]      ovr_clr;
    logic                  busy;
    logic                  done;
    logic                  timeout;

    int   total = 0;
    int   bad   = 0;
    vec_t tbl[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    reg_ovr_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_val  (req_val),
        .req_mask (req_mask),
        .gnt      (gnt),
        .ovr_set  (ovr_set),
        .ovr_clr  (ovr_clr),
        .busy     (busy),
        .done     (done)
`ifdef OVR_TIMEOUT_EN
        ,
        .timeout  (timeout)
`endif
    );

`ifndef OVR_TIMEOUT_EN
    assign timeout = 1'b0;
`endif

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [3:0] v,
                                input logic [31:0] m, input logic [3:0] g, input logic [7:0] s,
                                input logic [7:0] c, input logic b, input logic d, input logic t,
                                input string nm);
        vec_t x;
        x.rst = r; x.req = rq; x.val = v; x.mask = m;
        x.gnt = g; x.set = s; x.clr = c; x.busy = b; x.done = d; x.to = t; x.name = nm;
        return x;
    endfunction

    // Pop the oldest expectation and compare it with the outputs after the edge
    task automatic check_out();
        vec_t        e;
        logic [22:0] act;
        logic [22:0] want;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty: no expectation queued at t=%0t", $time);
            return;
        end
        e    = exp_q.pop_front();
        act  = {gnt, ovr_set, ovr_clr, busy, done, timeout};
        want = {e.gnt, e.set, e.clr, e.busy, e.done, e.to};
        if (act !== want)
            begin
            bad++;
            $display("FAIL %s: got gnt=%b set=%h clr=%h busy=%b done=%b to=%b, want gnt=%b set=%h clr=%h busy=%b done=%b to=%b",
                     e.name, gnt, ovr_set, ovr_clr, busy, done, timeout,
                     e.gnt, e.set, e.clr, e.busy, e.done, e.to);
        end
    endtask

    task automatic step(input vec_t v);
        rst      = v.rst;
        req      = v.req;
        req_val  = v.val;
        req_mask = v.mask;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req = '0; req_val = '0; req_mask = '0;

        // reset, then single set override by requester 1
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 32'h0,         4'b0000, 8'h00, 8'h00, 0, 0, 0, "reset"));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,         4'b0000, 8'h00, 8'h00, 0, 0, 0, "idle"));
        tbl.push_back(mk(0, 4'b0010, 4'b0010, 32'h0000_0F00, 4'b0010, 8'h0F, 8'h00, 1, 0, 0, "single_apply"));
        tbl.push_back(mk(0, 4'b0010, 4'b0010, 32'h0000_0F00, 4'b0010, 8'h0F, 8'h00, 1, 0, 0, "single_hold0"));
        tbl.push_back(mk(0, 4'b0010, 4'b0010, 32'h0000_0F00, 4'b0010, 8'h0F, 8'h00, 1, 0, 0, "single_hold1"));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,         4'b0000, 8'h00, 8'h00, 1, 1, 0, "single_release"));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,         4'b0000, 8'h00, 8'h00, 0, 0, 0, "single_idle"));
        // clear override by requester 2; later mask/val changes are ignored
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 32'h00A5_0000, 4'b0100, 8'h00, 8'hA5, 1, 0, 0, "clr_apply"));
        tbl.push_back(mk(0, 4'b0100, 4'b0100, 32'hFFFF_FFFF, 4'b0100, 8'h00, 8'hA5, 1, 0, 0, "clr_hold_chg0"));
        tbl.push_back(mk(0, 4'b0100, 4'b0100, 32'h00FF_0000, 4'b0100, 8'h00, 8'hA5, 1, 0, 0, "clr_hold_chg1"));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,         4'b0000, 8'h00, 8'h00, 1, 1, 0, "clr_release"));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,         4'b0000, 8'h00, 8'h00, 0, 0, 0, "clr_idle"));
        // pointer back to 0, then three simultaneous requesters served 0, 1, 3
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 32'h0,         4'b0000, 8'h00, 8'h00, 0, 0, 0, "rr_reset"));
        tbl.push_back(mk(0, 4'b1011, 4'b1011, 32'h8000_0201, 4'b0001, 8'h01, 8'h00, 1, 0, 0, "rr_g0_apply"));
        tbl.push_back(mk(0, 4'b1011, 4'b1011, 32'h8000_0201, 4'b0001, 8'h01, 8'h00, 1, 0, 0, "rr_g0_hold"));
        tbl.push_back(mk(0, 4'b1010, 4'b1011, 32'h8000_0201, 4'b0000, 8'h00, 8'h00, 1, 1, 0, "rr_g0_release"));
        tbl.push_back(mk(0, 4'b1010, 4'b1011, 32'h8000_0201, 4'b0000, 8'h00, 8'h00, 0, 0, 0, "rr_idle0"));
        tbl.push_back(mk(0, 4'b1010, 4'b1011, 32'h8000_0201, 4'b0010, 8'h02, 8'h00, 1, 0, 0, "rr_g1_apply"));
        tbl.push_back(mk(0, 4'b1010, 4'b1011, 32'h8000_0201, 4'b0010, 8'h02, 8'h00, 1, 0, 0, "rr_g1_hold"));
        tbl.push_back(mk(0, 4'b1000, 4'b1011, 32'h8000_0201, 4'b0000, 8'h00, 8'h00, 1, 1, 0, "rr_g1_release"));
        tbl.push_back(mk(0, 4'b1000, 4'b1011, 32'h8000_0201, 4'b0000, 8'h00, 8'h00, 0, 0, 0, "rr_idle1"));
        tbl.push_back(mk(0, 4'b1000, 4'b1011, 32'h8000_0201, 4'b1000, 8'h80, 8'h00, 1, 0, 0, "rr_g3_apply"));
        // owner 3 drops during APPLY: still one HOLD cycle
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,         4'b1000, 8'h80, 8'h00, 1, 0, 0, "early_hold"));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,         4'b0000, 8'h00, 8'h00, 1, 1, 0, "early_release"));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,         4'b0000, 8'h00, 8'h00, 0, 0, 0, "early_idle"));
        // all-zero mask still runs the full sequence
        tbl.push_back(mk(0, 4'b0001, 4'b0001, 32'h0,         4'b0001, 8'h00, 8'h00, 1, 0, 0, "zmask_apply"));
        tbl.push_back(mk(0, 4'b0000, 4'b0001, 32'h0,         4'b0001, 8'h00, 8'h00, 1, 0, 0, "zmask_hold"));
        tbl.push_back(mk(0, 4'b0000, 4'b0001, 32'h0,         4'b0000, 8'h00, 8'h00, 1, 1, 0, "zmask_release"));
        tbl.push_back(mk(0, 4'b0000, 4'b0001, 32'h0,         4'b0000, 8'h00, 8'h00, 0, 0, 0, "zmask_idle"));
        // reset in HOLD: no done, pointer back to 0 (req 0110 must grant 1, not 2)
        tbl.push_back(mk(0, 4'b0010, 4'b0010, 32'h0000_3C00, 4'b0010, 8'h3C, 8'h00, 1, 0, 0, "rsth_apply"));
        tbl.push_back(mk(0, 4'b0010, 4'b0010, 32'h0000_3C00, 4'b0010, 8'h3C, 8'h00, 1, 0, 0, "rsth_hold"));
        tbl.push_back(mk(1, 4'b0010, 4'b0010, 32'h0000_3C00, 4'b0000, 8'h00, 8'h00, 0, 0, 0, "rsth_reset"));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,         4'b0000, 8'h00, 8'h00, 0, 0, 0, "rsth_no_done"));
        tbl.push_back(mk(0, 4'b0110, 4'b0000, 32'h0000_1100, 4'b0010, 8'h00, 8'h11, 1, 0, 0, "rsth_ptr0"));
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 32'h0000_1100, 4'b0010, 8'h00, 8'h11, 1, 0, 0, "rsth_hold2"));
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 32'h0000_1100, 4'b0000, 8'h00, 8'h00, 1, 1, 0, "rsth_release"));
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 32'h0000_1100, 4'b0000, 8'h00, 8'h00, 0, 0, 0, "rsth_idle"));
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 32'h0000_1100, 4'b0100, 8'h00, 8'h00, 1, 0, 0, "late_g2_apply"));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,         4'b0100, 8'h00, 8'h00, 1, 0, 0, "late_g2_hold"));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,         4'b0000, 8'h00, 8'h00, 1, 1, 0, "late_g2_release"));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,         4'b0000, 8'h00, 8'h00, 0, 0, 0, "late_g2_idle"));

        foreach (tbl[i]) step(tbl[i]);

        // long hold by requester 3 (pointer is now 3)
        step(mk(0, 4'b1000, 4'b1000, 32'hFF00_0000, 4'b1000, 8'hFF, 8'h00, 1, 0, 0, "long_apply"));
`ifdef OVR_TIMEOUT_EN
        for (int k = 0; k < int'(MAX_HOLD); k++)
            step(mk(0, 4'b1000, 4'b1000, 32'hFF00_0000, 4'b1000, 8'hFF, 8'h00, 1, 0, 0, "to_hold"));
        step(mk(0, 4'b1000, 4'b1000, 32'hFF00_0000, 4'b0000, 8'h00, 8'h00, 1, 1, 1, "to_release"));
        step(mk(0, 4'b0000, 4'b0000, 32'h0,         4'b0000, 8'h00, 8'h00, 0, 0, 0, "to_idle"));
`else
        for (int k = 0; k < int'(MAX_HOLD) + 4; k++)
            step(mk(0, 4'b1000, 4'b1000, 32'hFF00_0000, 4'b1000, 8'hFF, 8'h00, 1, 0, 0, "unbounded_hold"));
        step(mk(0, 4'b0000, 4'b0000, 32'h0,         4'b0000, 8'h00, 8'h00, 1, 1, 0, "unbounded_release"));
        step(mk(0, 4'b0000, 4'b0000, 32'h0,         4'b0000, 8'h00, 8'h00, 0, 0, 0, "unbounded_idle"));
`endif
        // pointer wrapped from 3 to 0
        step(mk(0, 4'b1001, 4'b0001, 32'h0000_0042, 4'b0001, 8'h42, 8'h00, 1, 0, 0, "wrap_apply"));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
